alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Command-side driver for the 128-bit combinational ALU in the datapath.
- Accepts one operation at a time over a valid/ready command interface and registers the operands, opsel and mode onto the ALU input pins.
- Waits a programmable settle time, then captures the ALU result and the c/z/o/s flags.
- Returns the captured result and flags over a valid/ready response interface. Also keeps a free-running completed-operation count.

Parameters:
- DWIDTH, 128, operand/result width; must match the ALU.
- SETTLE, 2, cycles from operand drive to result capture; legal range 1..15.
- CWIDTH, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op1  input  DWIDTH  operand 1.
- cmd_op2  input  DWIDTH  operand 2.
- cmd_opsel  input  3  ALU operation select.
- cmd_mode  input  1  ALU mode bit.
- alu_op1  output  DWIDTH  registered drive to ALU op1.
- alu_op2  output  DWIDTH  registered drive to ALU op2.
- alu_opsel  output  3  registered drive to ALU opsel.
- alu_mode  output  1  registered drive to ALU mode.
- alu_result  input  DWIDTH  ALU result.
- alu_c, alu_z, alu_o, alu_s  input  1 each  ALU carry, zero, overflow and sign flags.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  DWIDTH  captured result.
- rsp_flags  output  4  captured flags, packed {c,z,o,s} (bit3 = c … bit0 = s).
- busy  output  1  high in WAIT or RESP.
- op_count  output  CWIDTH  completed responses, wraps modulo 2^CWIDTH.

Behaviour:
- Reset: rst_n low asynchronously forces every output and internal register to 0 and the FSM to IDLE. Registered outputs are alu_*, rsp_*, op_count and the settle counter. cmd_ready is combinational (1 in IDLE) and reads 1 during reset. Reset mid-operation abandons the operation; no response is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid=1 at a rising edge: load alu_op1/op2/opsel/mode from cmd_*, load settle counter with SETTLE-1, go to WAIT.
- WAIT:
  - cmd_ready=0.
  - If the counter is nonzero, decrement it.
  - If the counter is 0: capture alu_result into rsp_result and {alu_c,alu_z,alu_o,alu_s} into rsp_flags, set rsp_valid=1, go to RESP.
- RESP:
  - cmd_ready=0; rsp_valid, rsp_result and rsp_flags stay stable.
  - On rsp_ready=1 at a rising edge: clear rsp_valid, increment op_count, go to IDLE.
  - rsp_ready is ignored whenever rsp_valid=0.
- Latency: if a command is accepted at edge N, rsp_valid rises after edge N+SETTLE. The earliest next command is accepted at the edge after the response handshake. With rsp_ready held high, issue interval = SETTLE+2 cycles.
- Drive stability:
  - alu_* change only on command acceptance, so they are stable throughout WAIT and RESP.
  - After the response, alu_* keep the last command's values (no return to 0).
- rsp_result/rsp_flags keep their last captured values after the handshake until the next capture.
- The ALU inputs are sampled only at the capture edge. Changes on alu_result or flags in any other cycle have no effect.
- cmd_* changing while cmd_ready=0 has no effect.
- op_count wraps from 2^CWIDTH-1 to 0 silently.
- SETTLE=1: capture happens on the first WAIT edge. Values outside 1..15 are a configuration error; the block flags this at elaboration.

Test Plan:
- Bench ALU model: opsel 0 = add. Reset, then cmd op1=5, op2=7, opsel=0, mode=0 with rsp_ready=1. Required: alu_op1=5 the cycle after acceptance; rsp_valid rises exactly 2 edges after acceptance; rsp_result=12, rsp_flags=4'b0000; op_count=1.
- Add with op1=all-ones, op2=1. Required: rsp_result=0, rsp_flags=4'b1100 (carry and zero set).
- Hold rsp_ready=0 for 10 cycles after rsp_valid rises, and pulse cmd_valid with new operands during that time. Required: rsp_valid, rsp_result and alu_* unchanged; cmd_ready=0; the new command is not taken; op_count increments once when rsp_ready rises.
- Back-to-back commands with rsp_ready=1. Required: accepts spaced SETTLE+2 cycles apart; responses in order; op_count matches the number of handshakes.
- Assert rst_n=0 in WAIT. Required: all outputs 0 immediately (asynchronous); no rsp_valid after release; cmd_ready=1 after release.
- CWIDTH=2 build, 5 operations. Required: op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command/response handshake bundle for alu_op_sequencer
interface alu_op_sequencer_if #(
    parameter int DWIDTH = 128
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DWIDTH-1:0] cmd_op1;
    logic [DWIDTH-1:0] cmd_op2;
    logic [2:0]        cmd_opsel;
    logic              cmd_mode;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_result;
    logic [3:0]        rsp_flags;

    modport master (
        output cmd_valid, cmd_op1, cmd_op2, cmd_opsel, cmd_mode, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  cmd_valid, cmd_op1, cmd_op2, cmd_opsel, cmd_mode, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - drives one op onto the combinational ALU, waits SETTLE cycles, returns result/flags
module alu_op_sequencer #(
    parameter int DWIDTH = 128,
    parameter int SETTLE = 2,
    parameter int CWIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus,
    output logic [DWIDTH-1:0]  alu_op1,
    output logic [DWIDTH-1:0]  alu_op2,
    output logic [2:0]         alu_opsel,
    output logic               alu_mode,
    input  logic [DWIDTH-1:0]  alu_result,
    input  logic               alu_c,
    input  logic               alu_z,
    input  logic               alu_o,
    input  logic               alu_s,
    output logic               busy,
    output logic [CWIDTH-1:0]  op_count
);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
            $fatal(1, "alu_op_sequencer: SETTLE must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] LP_CNT_INIT = 4'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic               w_capture;
    logic               w_done;
    logic [3:0]         r_cnt;
    logic [DWIDTH-1:0]  r_alu_op1;
    logic [DWIDTH-1:0]  r_alu_op2;
    logic [2:0]         r_alu_opsel;
    logic               r_alu_mode;
    logic               r_rsp_valid;
    logic [DWIDTH-1:0]  r_rsp_result;
    logic [3:0]         r_rsp_flags;
    logic [CWIDTH-1:0]  r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_IDLE: if (bus.cmd_valid) begin
                w_accept = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT: if (r_cnt == 4'd0) begin
                w_capture = 1'b1;
                w_next    = S_RESP;
            end
            S_RESP: if (bus.rsp_ready) begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ALU drive and response registers hold their values between operations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_opsel  <= '0;
            r_alu_mode   <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_op_count   <= '0;
        end else begin
            if (w_accept) begin
                r_alu_op1   <= bus.cmd_op1;
                r_alu_op2   <= bus.cmd_op2;
                r_alu_opsel <= bus.cmd_opsel;
                r_alu_mode  <= bus.cmd_mode;
                r_cnt       <= LP_CNT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rsp_result <= alu_result;
                r_rsp_flags  <= {alu_c, alu_z, alu_o, alu_s};
                r_rsp_valid  <= 1'b1;
            end
            if (w_done) begin
                r_rsp_valid <= 1'b0;
                r_op_count  <= r_op_count + 1'b1;
            end
        end
    end

    assign bus.cmd_ready  = (r_state == S_IDLE);
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign alu_op1        = r_alu_op1;
    assign alu_op2        = r_alu_op2;
    assign alu_opsel      = r_alu_opsel;
    assign alu_mode       = r_alu_mode;
    assign busy           = (r_state != S_IDLE);
    assign op_count       = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a behavioural add/and ALU
module tb_alu_op_sequencer;
    localparam int DW = 128;
    localparam int ST = 2;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   hs_count = 0;
    logic [131:0] exp_q[$];

    alu_op_sequencer_if #(.DWIDTH(DW)) b1 ();
    alu_op_sequencer_if #(.DWIDTH(DW)) b2 ();

    logic [DW-1:0] a1_op1, a1_op2, a1_res;
    logic [2:0]    a1_opsel;
    logic          a1_mode, a1_c, a1_z, a1_o, a1_s, busy1;
    logic [15:0]   op_count1;
    logic [DW-1:0] a2_op1, a2_op2, a2_res;
    logic [2:0]    a2_opsel;
    logic          a2_mode, a2_c, a2_z, a2_o, a2_s, busy2;
    logic [1:0]    op_count2;

    function automatic logic [131:0] alu_f(input logic [127:0] a, input logic [127:0] b,
                                           input logic [2:0] sel);
        logic [128:0] s;
        logic [127:0] r;
        logic c, o;
        if (sel == 3'd0) begin
            s = {1'b0, a} + {1'b0, b};
            r = s[127:0];
            c = s[128];
            o = (a[127] == b[127]) && (r[127] != a[127]);
        end else begin
            r = a & b;
            c = 1'b0;
            o = 1'b0;
        end
        return {c, (r == '0), o, r[127], r};
    endfunction

    assign {a1_c, a1_z, a1_o, a1_s, a1_res} = alu_f(a1_op1, a1_op2, a1_opsel);
    assign {a2_c, a2_z, a2_o, a2_s, a2_res} = alu_f(a2_op1, a2_op2, a2_opsel);

    alu_op_sequencer #(.DWIDTH(DW), .SETTLE(ST), .CWIDTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1),
        .alu_op1(a1_op1), .alu_op2(a1_op2), .alu_opsel(a1_opsel), .alu_mode(a1_mode),
        .alu_result(a1_res), .alu_c(a1_c), .alu_z(a1_z), .alu_o(a1_o), .alu_s(a1_s),
        .busy(busy1), .op_count(op_count1)
    );

    alu_op_sequencer #(.DWIDTH(DW), .SETTLE(ST), .CWIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2),
        .alu_op1(a2_op1), .alu_op2(a2_op2), .alu_opsel(a2_opsel), .alu_mode(a2_mode),
        .alu_result(a2_res), .alu_c(a2_c), .alu_z(a2_z), .alu_o(a2_o), .alu_s(a2_s),
        .busy(busy2), .op_count(op_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Responses are popped in order the cycle before their handshake edge
    always @(negedge clk) begin
        if (rst_n && b1.rsp_valid && b1.rsp_ready) begin
            logic [131:0] e;
            check("sb_pending", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_result", b1.rsp_result, e[127:0]);
                check("sb_flags", b1.rsp_flags, e[131:128]);
            end
            hs_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] a, input logic [127:0] b, input logic [2:0] sel,
                        input logic m, output int acc);
        b1.cmd_valid = 1'b1;
        b1.cmd_op1   = a;
        b1.cmd_op2   = b;
        b1.cmd_opsel = sel;
        b1.cmd_mode  = m;
        for (int i = 0; i < 100 && !b1.cmd_ready; i++) tick();
        check("cmd_ready_timeout", b1.cmd_ready, 1);
        exp_q.push_back(alu_f(a, b, sel));
        tick();
        acc = cyc;
        b1.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rc);
        for (int i = 0; i < 100 && !b1.rsp_valid; i++) tick();
        check("rsp_timeout", b1.rsp_valid, 1);
        rc = cyc;
    endtask

    initial begin
        int acc, rc, prev_acc;
        logic [127:0] ones;
        logic [127:0] msb;
        logic [1:0]   seq2 [5];
        seq2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        ones = '1;
        msb  = 128'd1 << 127;

        rst_n = 1'b0;
        b1.cmd_valid = 0; b1.cmd_op1 = 0; b1.cmd_op2 = 0; b1.cmd_opsel = 0; b1.cmd_mode = 0;
        b1.rsp_ready = 0;
        b2.cmd_valid = 0; b2.cmd_op1 = 0; b2.cmd_op2 = 0; b2.cmd_opsel = 0; b2.cmd_mode = 0;
        b2.rsp_ready = 0;
        #12;
        check("rst_cmd_ready", b1.cmd_ready, 1);
        check("rst_rsp_valid", b1.rsp_valid, 0);
        check("rst_op_count", op_count1, 0);
        check("rst_alu_op1", a1_op1, 0);
        check("rst_busy", busy1, 0);
        rst_n = 1'b1;
        tick();

        // 5 + 7 with rsp_ready held high
        b1.rsp_ready = 1'b1;
        send(128'd5, 128'd7, 3'd0, 1'b0, acc);
        check("alu_op1_after_accept", a1_op1, 5);
        check("busy_in_wait", busy1, 1);
        wait_rsp(rc);
        check("rsp_latency", rc - acc, ST);
        check("add_result", b1.rsp_result, 12);
        check("add_flags", b1.rsp_flags, 4'b0000);
        tick();
        check("op_count_1", op_count1, 1);
        check("rsp_valid_cleared", b1.rsp_valid, 0);

        // carry out and zero
        send(ones, 128'd1, 3'd0, 1'b0, acc);
        wait_rsp(rc);
        check("wrap_result", b1.rsp_result, 0);
        check("wrap_flags", b1.rsp_flags, 4'b1100);
        tick();
        check("op_count_2", op_count1, 2);

        // response backpressure; a command offered meanwhile must be ignored
        b1.rsp_ready = 1'b0;
        send(128'd100, 128'd23, 3'd0, 1'b1, acc);
        wait_rsp(rc);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                b1.cmd_valid = 1'b1;
                b1.cmd_op1   = 128'd999;
                b1.cmd_op2   = 128'd1;
            end
            if (i == 6) b1.cmd_valid = 1'b0;
            tick();
            check("hold_rsp_valid", b1.rsp_valid, 1);
            check("hold_rsp_result", b1.rsp_result, 123);
            check("hold_alu_op1", a1_op1, 100);
            check("hold_cmd_ready", b1.cmd_ready, 0);
        end
        check("hold_alu_mode", a1_mode, 1);
        check("hold_op_count", op_count1, 2);
        b1.rsp_ready = 1'b1;
        tick();
        check("op_count_3", op_count1, 3);
        tick();
        check("no_stray_accept", busy1, 0);
        check("alu_op1_retained", a1_op1, 100);
        check("rsp_result_retained", b1.rsp_result, 123);

        // back-to-back issue
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: send(128'd3, 128'd4, 3'd0, 1'b0, acc);
                1: send(128'hF0, 128'h3C, 3'd1, 1'b0, acc);
                2: send(ones, ones, 3'd0, 1'b0, acc);
                default: send(msb, msb, 3'd0, 1'b0, acc);
            endcase
            if (k > 0) check("issue_interval", acc - prev_acc, ST + 2);
            prev_acc = acc;
        end
        wait_rsp(rc);
        tick();
        check("op_count_7", op_count1, 7);
        check("handshakes_7", hs_count, 7);
        check("sb_drained", exp_q.size(), 0);

        // asynchronous reset during WAIT
        send(128'd1, 128'd2, 3'd0, 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        check("arst_alu_op1", a1_op1, 0);
        check("arst_alu_op2", a1_op2, 0);
        check("arst_busy", busy1, 0);
        check("arst_cmd_ready", b1.cmd_ready, 1);
        check("arst_op_count", op_count1, 0);
        check("arst_rsp_result", b1.rsp_result, 0);
        #4 rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_rsp_valid", b1.rsp_valid, 0);
            check("post_rst_cmd_ready", b1.cmd_ready, 1);
        end
        check("post_rst_op_count", op_count1, 0);

        // narrow counter wraps
        b2.rsp_ready = 1'b1;
        b2.cmd_op1   = 128'd3;
        b2.cmd_op2   = 128'd4;
        b2.cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 100 && !b2.rsp_valid; i++) tick();
            check("c2_rsp_valid", b2.rsp_valid, 1);
            check("c2_result", b2.rsp_result, 7);
            tick();
            if (k == 4) b2.cmd_valid = 1'b0;
            check("c2_op_count", op_count2, seq2[k]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
